// File: rtl/dmem_ctrl.sv
// dmem_ctrl: single-port synchronous data RAM behind a req/ack handshake with wait states, byte enables, clear sweep and bounds checking
module dmem_ctrl #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int DEPTH       = 8,
  parameter int WAIT_CYCLES = 0,
  parameter int INIT_CLEAR  = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req,
  input  logic                we,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] be,
  output logic [DATA_W-1:0]   rdata,
  output logic                ack,
  output logic                err,
  output logic                busy
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int NB = DATA_W / 8;
  typedef enum logic [1:0] {CLEAR, IDLE, WAIT, RESP} state_t;
  state_t state, state_nx;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] clr_idx;
  logic [3:0] wcnt;
  logic l_we, c_we, accept, commit, in_range;
  logic [ADDR_W-1:0] l_addr, c_addr;
  logic [DATA_W-1:0] l_wdata, c_wdata;
  logic [NB-1:0] l_be, c_be;
  // with no wait states the commit edge is the accept edge, so the live inputs are used there
  always_comb begin
    accept   = state == IDLE && req;
    c_we     = accept ? we : l_we;
    c_addr   = accept ? addr : l_addr;
    c_wdata  = accept ? wdata : l_wdata;
    c_be     = accept ? be : l_be;
    commit   = (accept && WAIT_CYCLES == 0) || (state == WAIT && wcnt == 4'(WAIT_CYCLES - 1));
    in_range = {1'b0, c_addr} < (ADDR_W + 1)'(DEPTH);
    ack      = state == RESP;
    busy     = state != IDLE;
  end
  always_comb begin
    state_nx = state;
    case (state)
      CLEAR: if (clr_idx == AW'(DEPTH - 1)) state_nx = IDLE;
      IDLE:  if (req) state_nx = WAIT_CYCLES > 0 ? WAIT : RESP;
      WAIT:  if (commit) state_nx = RESP;
      RESP:  state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= INIT_CLEAR != 0 ? CLEAR : IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      clr_idx <= '0;
      wcnt    <= '0;
      rdata   <= '0;
      err     <= 1'b0;
      l_we    <= 1'b0;
      l_addr  <= '0;
      l_wdata <= '0;
      l_be    <= '0;
    end else begin
      clr_idx <= state == CLEAR ? clr_idx + 1'b1 : '0;
      wcnt    <= state == WAIT ? wcnt + 1'b1 : '0;
      err     <= commit && !in_range;
      if (accept) begin
        l_we    <= we;
        l_addr  <= addr;
        l_wdata <= wdata;
        l_be    <= be;
      end
      if (commit && !c_we) rdata <= in_range ? mem[c_addr[AW-1:0]] : '0;
    end
  // storage has no reset; the rst_n gate keeps a held-in-reset controller from writing
  always_ff @(posedge clk)
    if (rst_n) begin
      if (state == CLEAR) mem[clr_idx] <= '0;
      else if (commit && c_we && in_range)
        for (int i = 0; i < NB; i++)
          if (c_be[i]) mem[c_addr[AW-1:0]][8*i +: 8] <= c_wdata[8*i +: 8];
    end
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed checks of dmem_ctrl with two wait states plus clear sweep, and with zero wait states and no sweep
module tb_dmem_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic a_rst_n, a_req, a_we, a_ack, a_err, a_busy;
  logic [15:0] a_addr, a_wdata, a_rdata;
  logic [1:0] a_be;
  logic b_rst_n, b_req, b_we, b_ack, b_err, b_busy;
  logic [15:0] b_addr, b_wdata, b_rdata;
  logic [1:0] b_be;
  int checks = 0, failures = 0;
  logic [15:0] rd;
  logic e;
  int lat;
  dmem_ctrl #(.DATA_W(16), .ADDR_W(16), .DEPTH(8), .WAIT_CYCLES(2), .INIT_CLEAR(1)) u_a (
    .clk(clk), .rst_n(a_rst_n), .req(a_req), .we(a_we), .addr(a_addr), .wdata(a_wdata),
    .be(a_be), .rdata(a_rdata), .ack(a_ack), .err(a_err), .busy(a_busy));
  dmem_ctrl #(.DATA_W(16), .ADDR_W(16), .DEPTH(8), .WAIT_CYCLES(0), .INIT_CLEAR(0)) u_b (
    .clk(clk), .rst_n(b_rst_n), .req(b_req), .we(b_we), .addr(b_addr), .wdata(b_wdata),
    .be(b_be), .rdata(b_rdata), .ack(b_ack), .err(b_err), .busy(b_busy));

  task automatic a_xfer(input logic w, input logic [15:0] ad, input logic [15:0] wd, input logic [1:0] b,
                        output logic [15:0] r, output logic er, output int l);
    @(negedge clk);
    a_req = 1'b1; a_we = w; a_addr = ad; a_wdata = wd; a_be = b; l = 0;
    do begin @(negedge clk); l++; end while (!a_ack && l < 20);
    r = a_rdata; er = a_err; a_req = 1'b0;
  endtask

  task automatic b_xfer(input logic w, input logic [15:0] ad, input logic [15:0] wd, input logic [1:0] b,
                        output logic [15:0] r, output logic er, output int l);
    @(negedge clk);
    b_req = 1'b1; b_we = w; b_addr = ad; b_wdata = wd; b_be = b; l = 0;
    do begin @(negedge clk); l++; end while (!b_ack && l < 20);
    r = b_rdata; er = b_err; b_req = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    repeat (2) @(negedge clk);
    checks++;
    if ({a_busy, a_ack, a_err, a_rdata} !== {3'b100, 16'h0}) begin
      failures++; $display("FAIL reset_a busy/ack/err/rdata got=%b%b%b %h exp=100 0000", a_busy, a_ack, a_err, a_rdata);
    end
    checks++;
    if ({b_busy, b_ack, b_err, b_rdata} !== {3'b000, 16'h0}) begin
      failures++; $display("FAIL reset_b busy/ack/err/rdata got=%b%b%b %h exp=000 0000", b_busy, b_ack, b_err, b_rdata);
    end
    a_rst_n = 1'b1; b_rst_n = 1'b1;
    n = 0;
    while (a_busy && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (n !== 8) begin failures++; $display("FAIL clear_sweep busy cycles got=%0d exp=8", n); end
    checks++;
    if (b_busy !== 1'b0) begin failures++; $display("FAIL b_idle busy got=%b exp=0", b_busy); end
  endtask

  task automatic test_clear_reads();
    for (int i = 0; i < 8; i++) begin
      a_xfer(1'b0, 16'(i), 16'h0, 2'b11, rd, e, lat);
      checks++;
      if (rd !== 16'h0 || e !== 1'b0 || lat !== 3) begin
        failures++; $display("FAIL clear_read[%0d] rdata=%h err=%b lat=%0d exp 0000 0 3", i, rd, e, lat);
      end
    end
  endtask

  task automatic test_write_read();
    a_xfer(1'b1, 16'd3, 16'hA5C3, 2'b11, rd, e, lat);
    checks++;
    if (e !== 1'b0 || lat !== 3) begin failures++; $display("FAIL write3 err=%b lat=%0d exp 0 3", e, lat); end
    a_xfer(1'b0, 16'd3, 16'h0, 2'b00, rd, e, lat);
    checks++;
    if (rd !== 16'hA5C3 || e !== 1'b0 || lat !== 3) begin
      failures++; $display("FAIL read3 rdata=%h err=%b lat=%0d exp a5c3 0 3", rd, e, lat);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (a_rdata !== 16'hA5C3 || a_ack !== 1'b0 || a_busy !== 1'b0) begin
      failures++; $display("FAIL rdata_hold rdata=%h ack=%b busy=%b exp a5c3 0 0", a_rdata, a_ack, a_busy);
    end
  endtask

  task automatic test_byte_enable();
    a_xfer(1'b1, 16'd5, 16'h1234, 2'b11, rd, e, lat);
    a_xfer(1'b1, 16'd5, 16'hABCD, 2'b01, rd, e, lat);
    a_xfer(1'b0, 16'd5, 16'h0, 2'b00, rd, e, lat);
    checks++;
    if (rd !== 16'h12CD) begin failures++; $display("FAIL be_low got=%h exp=12cd", rd); end
    a_xfer(1'b1, 16'd5, 16'hEF00, 2'b10, rd, e, lat);
    a_xfer(1'b0, 16'd5, 16'h0, 2'b00, rd, e, lat);
    checks++;
    if (rd !== 16'hEFCD) begin failures++; $display("FAIL be_high got=%h exp=efcd", rd); end
    a_xfer(1'b1, 16'd5, 16'hFFFF, 2'b00, rd, e, lat);
    checks++;
    if (e !== 1'b0 || lat !== 3) begin failures++; $display("FAIL be_zero_ack err=%b lat=%0d exp 0 3", e, lat); end
    a_xfer(1'b0, 16'd5, 16'h0, 2'b00, rd, e, lat);
    checks++;
    if (rd !== 16'hEFCD) begin failures++; $display("FAIL be_zero_mem got=%h exp=efcd", rd); end
  endtask

  task automatic test_out_of_range();
    a_xfer(1'b1, 16'd1, 16'h5A5A, 2'b11, rd, e, lat);
    a_xfer(1'b0, 16'd1, 16'h0, 2'b00, rd, e, lat);
    a_xfer(1'b0, 16'h0008, 16'h0, 2'b00, rd, e, lat);
    checks++;
    if (rd !== 16'h0 || e !== 1'b1 || lat !== 3) begin
      failures++; $display("FAIL oor_read rdata=%h err=%b lat=%0d exp 0000 1 3", rd, e, lat);
    end
    @(negedge clk);
    checks++;
    if (a_err !== 1'b0 || a_ack !== 1'b0) begin failures++; $display("FAIL err_clear err=%b ack=%b exp 0 0", a_err, a_ack); end
    a_xfer(1'b0, 16'd1, 16'h0, 2'b00, rd, e, lat);
    a_xfer(1'b1, 16'h0009, 16'hFFFF, 2'b11, rd, e, lat);
    checks++;
    if (e !== 1'b1 || rd !== 16'h5A5A) begin failures++; $display("FAIL oor_write err=%b rdata=%h exp 1 5a5a", e, rd); end
    a_xfer(1'b0, 16'h8001, 16'h0, 2'b00, rd, e, lat);
    checks++;
    if (e !== 1'b1 || rd !== 16'h0) begin failures++; $display("FAIL oor_upper err=%b rdata=%h exp 1 0000", e, rd); end
    a_xfer(1'b0, 16'd1, 16'h0, 2'b00, rd, e, lat);
    checks++;
    if (e !== 1'b0 || rd !== 16'h5A5A) begin failures++; $display("FAIL no_wrap err=%b rdata=%h exp 0 5a5a", e, rd); end
  endtask

  task automatic test_back_to_back();
    logic [6:0] ackv;
    int k;
    @(negedge clk);
    b_req = 1'b1; b_we = 1'b1; b_addr = 16'd0; b_wdata = 16'h1111; b_be = 2'b11; k = 0;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      ackv[i-1] = b_ack;
      if (b_ack) begin k++; b_addr = 16'(k); b_wdata = 16'(16'h1111 * (k + 1)); end
    end
    b_req = 1'b0;
    checks++;
    if (ackv !== 7'b1010101) begin failures++; $display("FAIL b2b_ack_pattern got=%b exp=1010101", ackv); end
    for (int i = 0; i < 4; i++) begin
      b_xfer(1'b0, 16'(i), 16'h0, 2'b00, rd, e, lat);
      checks++;
      if (rd !== 16'(16'h1111 * (i + 1)) || e !== 1'b0 || lat !== 1) begin
        failures++; $display("FAIL b2b_read[%0d] rdata=%h err=%b lat=%0d exp %h 0 1", i, rd, e, lat, 16'(16'h1111 * (i + 1)));
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    logic seen;
    a_xfer(1'b1, 16'd2, 16'h1357, 2'b11, rd, e, lat);
    a_xfer(1'b0, 16'd2, 16'h0, 2'b00, rd, e, lat);
    checks++;
    if (rd !== 16'h1357) begin failures++; $display("FAIL pre_abort_read got=%h exp=1357", rd); end
    @(negedge clk);
    a_req = 1'b1; a_we = 1'b1; a_addr = 16'd2; a_wdata = 16'hBEEF; a_be = 2'b11;
    @(negedge clk);
    checks++;
    if (a_busy !== 1'b1 || a_ack !== 1'b0) begin failures++; $display("FAIL in_wait busy=%b ack=%b exp 1 0", a_busy, a_ack); end
    a_rst_n = 1'b0;
    #1;
    checks++;
    if ({a_busy, a_ack, a_err, a_rdata} !== {3'b100, 16'h0}) begin
      failures++; $display("FAIL async_reset busy/ack/err/rdata got=%b%b%b %h exp=100 0000", a_busy, a_ack, a_err, a_rdata);
    end
    @(negedge clk); a_req = 1'b0;
    @(negedge clk); a_rst_n = 1'b1;
    n = 0; seen = 1'b0;
    while (a_busy && n < 50) begin @(negedge clk); n++; seen |= a_ack; end
    checks++;
    if (n !== 8 || seen !== 1'b0) begin failures++; $display("FAIL resweep cycles=%0d ack_seen=%b exp 8 0", n, seen); end
    a_xfer(1'b0, 16'd2, 16'h0, 2'b00, rd, e, lat);
    checks++;
    if (rd !== 16'h0) begin failures++; $display("FAIL swept_addr2 got=%h exp=0000", rd); end
    @(negedge clk);
    b_req = 1'b1; b_we = 1'b1; b_addr = 16'd2; b_wdata = 16'hDEAD; b_be = 2'b11; b_rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({b_busy, b_ack, b_rdata} !== {2'b00, 16'h0}) begin
      failures++; $display("FAIL b_reset busy/ack/rdata got=%b%b %h exp=00 0000", b_busy, b_ack, b_rdata);
    end
    b_req = 1'b0;
    @(negedge clk); b_rst_n = 1'b1;
    b_xfer(1'b0, 16'd2, 16'h0, 2'b00, rd, e, lat);
    checks++;
    if (rd !== 16'h3333) begin failures++; $display("FAIL b_no_clear_addr2 got=%h exp=3333", rd); end
  endtask

  initial begin
    a_rst_n = 1'b0; a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0; a_be = '0;
    b_rst_n = 1'b0; b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0; b_be = '0;
    test_reset();
    test_clear_reads();
    test_write_read();
    test_byte_enable();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
